uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Serial receive front end for the `io` peripheral block, 8N1 framing. It sits between the `rxd` pin and the `io` register decode and consumes the 16x baud pulse from the baud clock generator. It deserialises bytes and queues them in a small show-ahead FIFO. It presents the head byte and a ready flag to the CPU-facing read path, so several back-to-back bytes survive slow firmware polling.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `SYNC_STAGES`, default 2: flops in the `rxd` metastability synchroniser; at least 2.
- `clk`  in  1  system clock (50 MHz).
- `resetn`  in  1  asynchronous, active-low reset.
- `baudclk16`  in  1  one-`clk`-wide pulse at 16x baud (every 326 clks for 9600 baud).
- `rxd`  in  1  asynchronous serial line; idles high.
- `rd_strobe`  in  1  read request. It is a level held for one or more cycles per CPU access; a pop happens on the rising edge only.
- `clr_err`  in  1  single-cycle pulse that clears `frame_err` and `overrun`.
- `data`  out  8  FIFO head byte; 0 when empty.
- `ready`  out  1  FIFO non-empty.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- `rxd` passes through `SYNC_STAGES` flops; the output is `rxs`. All FSM decisions use `rxs`, and only in cycles where `baudclk16` = 1 ("tick").
- Tick counter is 4 bits; bit index is 3 bits; shift register is 8 bits, LSB first.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a tick with `rxs`=0, go to START and set tick counter = 0.
  - START: count ticks. At tick count 7 (mid start bit), if `rxs`=0 go to DATA (counter=0, bit=0); if `rxs`=1 it was a glitch, return to IDLE.
  - DATA: at tick count 15 sample `rxs` into `shift[bit]` and reset the counter. After bit 7 go to STOP.
  - STOP: at tick count 15 sample `rxs`.
    - If 1: push `shift` and return to IDLE.
    - If 0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: on a tick with `rxs`=1, go to IDLE.
- FIFO behaviour:
  - Pop when `rd_strobe`=1, `rd_strobe` was 0 in the previous cycle, and the FIFO is non-empty. A pop on empty is a no-op.
  - A push while full with no pop in the same cycle drops the byte and sets `overrun`.
  - Push and pop in the same cycle when full is allowed: the pop frees the slot, and `overrun` stays unchanged.
  - Read and write pointers carry one extra wrap bit.
- `clr_err` clears both sticky flags. An error event in the same cycle as `clr_err` wins, and the flag stays set.

## Timing
- Reset (asynchronous, `resetn`=0) sets:
  - FSM to IDLE;
  - synchroniser flops to 1;
  - FIFO empty;
  - `data`=0, `ready`=0, `frame_err`=0, `overrun`=0;
  - rising-edge detector history to 0.
- A reset mid-frame abandons the byte. After release, the FSM waits in IDLE for the next low tick, so a tail of the old frame may produce a spurious `frame_err`; this is accepted.
- Push happens on the `clk` edge of the stop-bit sample tick. `ready` and `data` update one `clk` later (registered outputs).
- A pop on edge N updates `data` to the next entry and `ready` at edge N+1. `io` captures the old head on edge N, so each CPU read returns the correct byte.
- A frame takes 8 + 8·16 + 16 = 152 ticks from the falling edge to the push (plus up to 1 tick of detection delay and `SYNC_STAGES` clks of synchroniser delay).
- `rd_strobe` held high for any number of cycles pops exactly once.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - constants `TICKS_PER_BIT`=16 and `MID_START`=7.
- One sub-module, `rx_fifo`: synchronous show-ahead FIFO parameterised by width and depth, exposing `push`, `pop`, `din`, `dout`, `empty`, `full`.
- The FSM, synchroniser, edge detector and error flags live in `uart_rx_buffered`.

## Test plan
- Single byte 0xA5 sent at 9600 baud, with `baudclk16` every 326 clks -> `ready`=1 with `data`=0xA5 at 152±1 ticks after the falling edge; `frame_err`=0.
- Glitch: `rxd` low for 3 ticks, then high -> no push, FSM back in IDLE, `ready` stays 0.
- Bytes 0x01, 0x02, 0x03, 0x04, 0x05 with no reads, `FIFO_DEPTH`=4 -> `overrun`=1. Then four read pulses, each 2 cycles long, return 0x01, 0x02, 0x03, 0x04, then `ready`=0.
- Stop bit forced low on byte 0x3C -> `frame_err`=1, no push. The line then held low for 40 ticks and released -> no spurious bytes. `clr_err` -> flags return to 0.
- FIFO full, with a read rising edge in the same cycle as the push of 0x77 -> no overrun; 0x77 becomes the last entry.
- `resetn` asserted at mid-DATA bit 4 -> all outputs read 0 immediately (asynchronous). After release, a clean byte 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_buffered_pkg.sv
// Shared types and constants for the buffered 8N1 UART receiver.
package uart_rx_buffered_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned TICKS_PER_BIT = 16;
  // Tick count at which the start bit is re-sampled (middle of the bit).
  localparam int unsigned MID_START     = 7;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the head entry.
// Pointers carry one extra wrap bit to tell full from empty.
module rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push while full is accepted then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage needs no reset; empty FIFO contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with rxd synchroniser, 16x oversampling FSM, show-ahead
// receive FIFO, rising-edge read pop and sticky frame/overrun flags.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       baudclk16,
  input  logic       rxd,
  input  logic       rd_strobe,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  rx_state_e              state_q;
  logic [3:0]             cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;

  logic                   last_tick;
  logic                   stop_sample;
  logic                   push;
  logic                   frame_set;

  logic                   rd_prev_q;
  logic                   pop;
  logic [7:0]             fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   overrun_set;

  logic [7:0]             data_q;
  logic                   ready_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  // Metastability synchroniser; idles high like the line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  assign last_tick   = (cnt_q == 4'(TICKS_PER_BIT - 1));
  // Push/error must land on the very edge of the stop-bit sample tick.
  assign stop_sample = baudclk16 && (state_q == StStop) && last_tick;
  assign push        = stop_sample && rxs;
  assign frame_set   = stop_sample && !rxs;

  // Receive FSM, advancing only on baud ticks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (baudclk16) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == 4'(MID_START)) begin
            if (!rxs) begin
              state_q <= StData;
              cnt_q   <= '0;
              bit_q   <= '0;
            end else begin
              // Start bit did not hold: treat as a glitch.
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StData: begin
          if (last_tick) begin
            shift_q[bit_q] <= rxs;
            cnt_q          <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StStop: begin
          if (last_tick) begin
            cnt_q   <= '0;
            state_q <= rxs ? StIdle : StBreak;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StBreak: begin
          // Wait for the line to return high before hunting for a start bit.
          if (rxs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read strobe history for rising-edge pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_prev_q <= 1'b0;
    end else begin
      rd_prev_q <= rd_strobe;
    end
  end

  assign pop         = rd_strobe && !rd_prev_q && !fifo_empty;
  assign overrun_set = push && fifo_full && !pop;

  rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (shift_q),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Registered CPU-facing outputs; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q      <= '0;
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      data_q      <= fifo_empty ? 8'h00 : fifo_dout;
      ready_q     <= !fifo_empty;
      frame_err_q <= frame_set | (frame_err_q & ~clr_err);
      overrun_q   <= overrun_set | (overrun_q & ~clr_err);
    end
  end

  assign data      = data_q;
  assign ready     = ready_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: the stimulus side models the FIFO as
// a queue of expected bytes plus expected flags; a monitor compares the head
// byte whenever a read rising edge is presented to the DUT.
module tb_uart_rx_buffered;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BAUD_DIV = 4;  // clks per 16x tick, shortened for sim time

  logic       clk       = 1'b0;
  logic       resetn    = 1'b0;
  logic       baudclk16 = 1'b0;
  logic       rxd       = 1'b1;
  logic       rd_strobe = 1'b0;
  logic       clr_err   = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  byte unsigned exp_q[$];
  bit           exp_fe = 1'b0;
  bit           exp_ov = 1'b0;

  uart_rx_buffered #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .baudclk16 (baudclk16),
    .rxd       (rxd),
    .rd_strobe (rd_strobe),
    .clr_err   (clr_err),
    .data      (data),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial forever #5 clk = ~clk;

  // Free-running one-clk tick every BAUD_DIV clks, changed on negedges.
  initial forever begin
    repeat (BAUD_DIV - 1) @(negedge clk);
    baudclk16 = 1'b1;
    @(negedge clk);
    baudclk16 = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baudclk16 !== 1'b1);
    #1;
  endtask

  // Sends one frame; returns just after the stop-bit sample edge.
  task automatic send_frame(input byte unsigned b, input bit stop_ok, input bit rd_at_push);
    wait_tick();
    rxd = 1'b0;
    repeat (16) wait_tick();
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (16) wait_tick();
    end
    rxd = stop_ok;
    repeat (8) wait_tick();
    if (rd_at_push) begin
      repeat (BAUD_DIV - 1) @(posedge clk);
      #1 rd_strobe = 1'b1;
    end
    wait_tick();
    if (rd_at_push) rd_strobe = 1'b0;
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ov = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic do_read(input int len);
    repeat (2) @(posedge clk);
    #1 rd_strobe = 1'b1;
    repeat (len) @(posedge clk);
    #1 rd_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_ready"}, ready, exp_q.size() != 0);
    chk({name, "_frame_err"}, frame_err, exp_fe);
    chk({name, "_overrun"}, overrun, exp_ov);
    if (exp_q.size() != 0) chk({name, "_data"}, data, exp_q[0]);
    else chk({name, "_data_empty"}, data, 0);
  endtask

  // Monitor: on every read rising edge, the head byte must match the model.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev = 1'b0;
      end else begin
        if (rd_strobe && !prev) begin
          chk("rd_ready", ready, exp_q.size() != 0);
          if (exp_q.size() != 0) chk("rd_data", data, exp_q.pop_front());
        end
        prev = rd_strobe;
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned b;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    resetn = 1'b1;
    repeat (10) wait_tick();

    // Single byte: nothing visible on the push edge, visible one clk later.
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_ready_at_push", ready, 0);
    @(posedge clk);
    #1;
    chk("a5_ready_next", ready, 1);
    chk("a5_data_next", data, 8'hA5);
    check_state("a5");
    do_read(1);
    check_state("a5_read");

    // Start-bit glitch.
    wait_tick();
    rxd = 1'b0;
    repeat (3) wait_tick();
    rxd = 1'b1;
    repeat (20) wait_tick();
    check_state("glitch");

    // Overrun: five bytes into a four-deep FIFO, then four 2-cycle reads.
    for (int i = 1; i <= 5; i++) send_frame(byte'(i), 1'b1, 1'b0);
    check_state("ovr");
    for (int i = 0; i < 4; i++) do_read(2);
    check_state("ovr_drained");

    // Framing error, long break, then clear.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) wait_tick();
    rxd = 1'b1;
    repeat (20) wait_tick();
    check_state("frame");
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    check_state("clr");

    // Full FIFO with a read rising edge on the push edge of 0x77.
    for (int i = 0; i < 4; i++) send_frame(byte'($urandom), 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    check_state("full_pop");
    for (int i = 0; i < 4; i++) do_read(1);
    check_state("full_pop_drained");

    // Random bytes with random reads.
    for (int i = 0; i < 8; i++) begin
      b = byte'($urandom);
      send_frame(b, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) do_read(int'($urandom_range(1, 4)));
    end
    check_state("rand");
    while (exp_q.size() != 0) do_read(int'($urandom_range(1, 3)));
    check_state("rand_drained");

    // Leave a byte and a framing error pending, then reset mid-DATA bit 4.
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (4) wait_tick();
    rxd = 1'b1;
    repeat (4) wait_tick();
    send_frame(8'hC3, 1'b1, 1'b0);
    check_state("pre_rst");
    b = 8'h96;
    wait_tick();
    rxd = 1'b0;
    repeat (16) wait_tick();
    for (int k = 0; k < 4; k++) begin
      rxd = b[k];
      repeat (16) wait_tick();
    end
    rxd = b[4];
    repeat (8) wait_tick();
    #2 resetn = 1'b0;
    #1;
    chk("midrst_ready", ready, 0);
    chk("midrst_data", data, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun", overrun, 0);
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) wait_tick();
    send_frame(8'h5A, 1'b1, 1'b0);
    check_state("post_rst");
    do_read(1);
    check_state("post_rst_read");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
